// File: rtl/calc_byte_sequencer.sv
// Byte-level front end for the 32-bit calculator core: assembles a 9-byte
// opcode/operand frame, waits out core latency and streams the 64-bit result back MSB first.
module calc_byte_sequencer #(
  parameter int unsigned CALC_LATENCY = 1,
  parameter logic [7:0]  IDLE_BYTE    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        frame_abort,
  input  logic        tx_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic [31:0] first_input_number,
  output logic [31:0] second_input_number,
  output logic [1:0]  operation,
  input  logic [63:0] result,
  output logic        busy,
  output logic        result_avail,
  output logic [1:0]  err_flags
);

  localparam int WAIT_W = (CALC_LATENCY < 2) ? 1 : $clog2(CALC_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CALC_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RX_OPS  = 2'd1,
    S_COMPUTE = 2'd2,
    S_READY   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        rx_cnt;
  logic [3:0]        tx_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [55:0]       shadow_ops;
  logic [1:0]        shadow_op;
  logic [63:0]       out_buf;

  logic start_frame;
  logic shift_byte;
  logic commit;
  logic abort;
  logic capture;
  logic overrun;

  logic        read_hit;
  logic [63:0] out_shifted;
  logic [7:0]  read_byte;

  // Control FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_byte  = 1'b0;
    commit      = 1'b0;
    abort       = 1'b0;
    capture     = 1'b0;
    overrun     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          start_frame = 1'b1;
          state_nxt   = S_RX_OPS;
        end
      end
      S_RX_OPS: begin
        // Abort takes priority; a byte arriving in the same cycle is dropped.
        if (frame_abort) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else if (rx_valid) begin
          if (rx_cnt == 4'd8) begin
            commit    = 1'b1;
            state_nxt = S_COMPUTE;
          end else begin
            shift_byte = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        overrun = rx_valid;
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (rx_valid) begin
          start_frame = 1'b1;
          state_nxt   = S_RX_OPS;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy         = (state == S_RX_OPS) || (state == S_COMPUTE);
  assign result_avail = (state == S_READY);

  // Frame assembly, core port commit and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt              <= 4'd0;
      wait_cnt            <= '0;
      shadow_ops          <= '0;
      shadow_op           <= 2'b00;
      first_input_number  <= 32'd0;
      second_input_number <= 32'd0;
      operation           <= 2'b00;
      out_buf             <= 64'd0;
      err_flags           <= 2'b00;
    end else begin
      if (start_frame) begin
        shadow_op  <= rx_data[1:0];
        shadow_ops <= '0;
        err_flags  <= {|rx_data[7:2], 1'b0};
        rx_cnt     <= 4'd1;
      end
      if (shift_byte) begin
        shadow_ops <= {shadow_ops[47:0], rx_data};
        rx_cnt     <= rx_cnt + 4'd1;
      end
      if (commit) begin
        first_input_number  <= shadow_ops[55:24];
        second_input_number <= {shadow_ops[23:0], rx_data};
        operation           <= shadow_op;
        wait_cnt            <= WAIT_INIT;
        rx_cnt              <= 4'd0;
      end
      if (abort) begin
        shadow_ops <= '0;
        rx_cnt     <= 4'd0;
      end
      if ((state == S_COMPUTE) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (capture) begin
        out_buf <= result;
      end
      if (overrun) begin
        err_flags[0] <= 1'b1;
      end
    end
  end

  // Byte selection: tx_cnt counts bytes already sent, MSB first
  assign read_hit    = (state == S_READY) && (tx_cnt != 4'd8);
  assign out_shifted = out_buf << {tx_cnt[2:0], 3'b000};
  assign read_byte   = out_shifted[63:56];

  // Read response: registered, one cycle after tx_req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_cnt   <= 4'd0;
    end else begin
      tx_valid <= tx_req;
      if (tx_req) begin
        tx_data <= read_hit ? read_byte : IDLE_BYTE;
      end
      if (capture) begin
        tx_cnt <= 4'd0;
      end else if (tx_req && read_hit) begin
        tx_cnt <= tx_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_calc_byte_sequencer.sv
// Directed and randomized bench for calc_byte_sequencer; includes a latency-accurate
// model of the calculator core and a frame-level reference for expected read bytes.
module tb_calc_byte_sequencer;

  localparam int unsigned L = 1;
  localparam logic [7:0] IDLE_B = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        frame_abort = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [31:0] first_input_number;
  logic [31:0] second_input_number;
  logic [1:0]  operation;
  logic [63:0] result;
  logic        busy;
  logic        result_avail;
  logic [1:0]  err_flags;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_a = 32'd0;
  logic [31:0] exp_b = 32'd0;
  logic [1:0]  exp_op = 2'b00;

  calc_byte_sequencer #(.CALC_LATENCY(L), .IDLE_BYTE(IDLE_B)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_abort(frame_abort),
    .tx_req(tx_req),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .first_input_number(first_input_number),
    .second_input_number(second_input_number),
    .operation(operation),
    .result(result),
    .busy(busy),
    .result_avail(result_avail),
    .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] core_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    case (op)
      2'b00:   return a64 + b64;
      2'b01:   return a64 - b64;
      2'b10:   return a64 * b64;
      default: return (b == 32'd0) ? 64'd0 : (a64 / b64);
    endcase
  endfunction

  // Core model: result valid L cycles after its inputs change
  logic [63:0] core_pipe [L];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(operation, first_input_number, second_input_number);
    for (int k = 1; k < L; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign result = core_pipe[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends bytes first_idx..8 of a frame; core ports must hold until byte8
  task automatic send_frame(input logic [7:0] opb, input logic [31:0] a, input logic [31:0] b,
                            input int first_idx);
    logic [7:0] bytes [9];
    bytes[0] = opb;
    for (int i = 0; i < 4; i++) begin
      bytes[1+i] = 8'(a >> (24 - 8*i));
      bytes[5+i] = 8'(b >> (24 - 8*i));
    end
    for (int i = first_idx; i < 9; i++) begin
      send_byte(bytes[i]);
      if (i == 0) chk("err_after_byte0", err_flags, {|opb[7:2], 1'b0});
      if (i < 8) begin
        chk("hold_a", first_input_number, exp_a);
        chk("hold_b", second_input_number, exp_b);
        chk("hold_op", operation, exp_op);
        chk("busy_rx", busy, 1);
      end
    end
    exp_a  = a;
    exp_b  = b;
    exp_op = opb[1:0];
    chk("commit_a", first_input_number, exp_a);
    chk("commit_b", second_input_number, exp_b);
    chk("commit_op", operation, exp_op);
    chk("busy_compute", busy, 1);
  endtask

  task automatic wait_result();
    repeat (L) begin
      tick();
      chk("avail_early", result_avail, 0);
    end
    tick();
    chk("avail", result_avail, 1);
    chk("busy_ready", busy, 0);
  endtask

  task automatic read_one(input logic [7:0] exp, input string tag);
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    chk({tag, "_valid"}, tx_valid, 1);
    chk(tag, tx_data, exp);
    tick();
    chk({tag, "_strobe"}, tx_valid, 0);
  endtask

  task automatic read_bytes(input logic [63:0] r, input int from, input int to);
    for (int i = from; i < to; i++)
      read_one((i < 8) ? 8'(r >> (56 - 8*i)) : IDLE_B, "rd_byte");
  endtask

  task automatic do_frame(input logic [7:0] opb, input logic [31:0] a, input logic [31:0] b);
    send_frame(opb, a, b, 0);
    wait_result();
    chk("err_frame", err_flags, {|opb[7:2], 1'b0});
    read_bytes(core_fn(opb[1:0], a, b), 0, 10);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_a"}, first_input_number, 0);
    chk({tag, "_b"}, second_input_number, 0);
    chk({tag, "_op"}, operation, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_avail"}, result_avail, 0);
    chk({tag, "_err"}, err_flags, 0);
    exp_a = 32'd0; exp_b = 32'd0; exp_op = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [7:0]  opb;
    logic [31:0] ra, rb;

    tick();
    do_reset("reset");

    // tx_req outside READY returns the idle byte
    read_one(IDLE_B, "idle_read");
    chk("idle_busy", busy, 0);

    // 1: add
    do_frame(8'h00, 32'h5, 32'h3);
    // 2: multiply
    do_frame(8'h02, 32'hFFFF_FFFF, 32'h2);
    // 3: divide by zero, then bad opcode byte still uses low bits
    do_frame(8'h03, 32'h1234_5678, 32'h0);
    do_frame(8'h07, 32'd100, 32'd7);
    chk("bad_op_used", operation, 2'b11);

    // 4: abort after byte4, then abort colliding with a byte, then full frame
    for (int i = 0; i < 5; i++) send_byte((i == 0) ? 8'h01 : ((i == 4) ? 8'h0A : 8'h00));
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_a", first_input_number, exp_a);
    chk("abort_b", second_input_number, exp_b);
    send_byte(8'h01);
    rx_data = 8'h00; rx_valid = 1'b1; frame_abort = 1'b1;
    tick();
    rx_valid = 1'b0; frame_abort = 1'b0;
    chk("abort_wins", busy, 0);
    do_frame(8'h01, 32'h0000_000A, 32'h0000_0004);

    // 5: overrun during COMPUTE
    send_frame(8'h00, 32'd1000, 32'd24, 0);
    send_byte(8'h55);
    tick();
    chk("ovr_avail", result_avail, 1);
    chk("ovr_err", err_flags, 2'b01);
    read_bytes(core_fn(2'b00, 32'd1000, 32'd24), 0, 9);
    send_byte(8'h01);
    chk("ovr_cleared", err_flags, 2'b00);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;

    // Read and new frame start in the same READY cycle
    send_frame(8'h01, 32'hDEAD_BEEF, 32'h0000_0001, 0);
    wait_result();
    r = core_fn(2'b01, 32'hDEAD_BEEF, 32'h0000_0001);
    read_bytes(r, 0, 2);
    tx_req = 1'b1; rx_data = 8'h02; rx_valid = 1'b1;
    tick();
    tx_req = 1'b0; rx_valid = 1'b0;
    chk("coll_valid", tx_valid, 1);
    chk("coll_byte", tx_data, 8'(r >> 40));
    chk("coll_avail", result_avail, 0);
    chk("coll_busy", busy, 1);
    send_frame(8'h02, 32'h0001_0000, 32'h0001_0000, 1);
    wait_result();
    read_bytes(core_fn(2'b10, 32'h0001_0000, 32'h0001_0000), 0, 9);

    // 6: reset mid-frame and mid-read
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    do_reset("rst_rx");
    do_frame(8'h00, 32'h8000_0000, 32'h8000_0000);
    send_frame(8'h02, 32'h0000_0100, 32'h0000_0100, 0);
    wait_result();
    read_bytes(core_fn(2'b10, 32'h0000_0100, 32'h0000_0100), 0, 3);
    do_reset("rst_rd");
    read_one(IDLE_B, "post_rst_read");
    do_frame(8'h01, 32'd4, 32'd9);

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      opb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      do_frame(opb, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
